// File: rtl/apb_mst_arbiter.sv
// Round-robin arbiter sharing one APB master port among NUM_REQ requesters,
// with IDLE/SETUP/ACCESS sequencing, pready wait states and an ACCESS watchdog.
module apb_mst_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ-1:0]    req_write,
  input  logic [NUM_REQ*AW-1:0] req_addr,
  input  logic [NUM_REQ*DW-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    done,
  output logic [DW-1:0]         rsp_rdata,
  output logic                  rsp_slverr,
  output logic                  busy,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [AW-1:0]         paddr,
  output logic [DW-1:0]         pwdata,
  input  logic [DW-1:0]         prdata,
  input  logic                  pready,
  input  logic                  pslverr
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam bit WD_EN = (TIMEOUT > 0);
  localparam logic [WDW-1:0] WD_LAST = WDW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t           state;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   gnt_id;
  logic [IDW-1:0]   win_id;
  logic [IDW-1:0]   scan_idx;
  logic [IDW-1:0]   ptr_nxt;
  logic             win_vld;
  logic [WDW-1:0]   wd_cnt;
  logic             wd_expire;
  logic [NUM_REQ-1:0] gnt_onehot;

  // Scan starting at ptr; the first asserted request wins.
  always_comb begin
    win_vld  = 1'b0;
    win_id   = '0;
    scan_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = IDW'((int'(ptr) + k) % NUM_REQ);
      if (!win_vld && req[scan_idx]) begin
        win_vld = 1'b1;
        win_id  = scan_idx;
      end
    end
  end

  assign ptr_nxt    = (win_id == IDW'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;
  assign wd_expire  = WD_EN && !pready && (wd_cnt == WD_LAST);
  assign gnt_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << gnt_id;
  assign busy       = (state != IDLE);

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state      <= IDLE;
      ptr        <= '0;
      gnt_id     <= '0;
      wd_cnt     <= '0;
      psel       <= 1'b0;
      penable    <= 1'b0;
      pwrite     <= 1'b0;
      paddr      <= '0;
      pwdata     <= '0;
      done       <= '0;
      rsp_rdata  <= '0;
      rsp_slverr <= 1'b0;
    end else begin
      done <= '0;
      case (state)
        IDLE: begin
          if (win_vld) begin
            state   <= SETUP;
            psel    <= 1'b1;
            penable <= 1'b0;
            gnt_id  <= win_id;
            pwrite  <= req_write[win_id];
            paddr   <= req_addr[int'(win_id)*AW +: AW];
            pwdata  <= req_wdata[int'(win_id)*DW +: DW];
            ptr     <= ptr_nxt;
          end
        end
        SETUP: begin
          state   <= ACCESS;
          penable <= 1'b1;
          wd_cnt  <= '0;
        end
        ACCESS: begin
          // pready on the expiry cycle takes precedence over the watchdog.
          if (pready || wd_expire) begin
            state      <= IDLE;
            psel       <= 1'b0;
            penable    <= 1'b0;
            done       <= gnt_onehot;
            rsp_slverr <= pready ? pslverr : 1'b1;
            rsp_rdata  <= (pready && !pwrite) ? prdata : '0;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_mst_arbiter.sv
// Directed bench for apb_mst_arbiter: latency, readback, fairness, wait
// states, watchdog expiry and asynchronous reset mid-transfer.
module tb_apb_mst_arbiter;
  localparam int NUM_REQ = 4;
  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int TIMEOUT = 16;

  logic                  pclk = 1'b0;
  logic                  presetn;
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ-1:0]    req_write;
  logic [NUM_REQ*AW-1:0] req_addr;
  logic [NUM_REQ*DW-1:0] req_wdata;
  logic [NUM_REQ-1:0]    done;
  logic [DW-1:0]         rsp_rdata;
  logic                  rsp_slverr;
  logic                  busy;
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [AW-1:0]         paddr;
  logic [DW-1:0]         pwdata;
  logic [DW-1:0]         prdata;
  logic                  pready;
  logic                  pslverr;

  int n_cmp = 0;
  int n_err = 0;

  apb_mst_arbiter #(.NUM_REQ(NUM_REQ), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .pclk(pclk), .presetn(presetn), .req(req), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .done(done),
    .rsp_rdata(rsp_rdata), .rsp_slverr(rsp_slverr), .busy(busy),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  // Simple slave: 16 words; unwritten words read back as 0xDEAD_00ii.
  logic [31:0] mem [16];
  logic [15:0] wr_seen = '0;
  logic [3:0]  sidx;
  assign sidx   = paddr[5:2];
  assign prdata = wr_seen[sidx] ? mem[sidx] : (32'hDEAD_0000 | 32'(sidx));

  always @(posedge pclk) begin
    if (psel && penable && pready && pwrite) begin
      mem[sidx]     <= pwdata;
      wr_seen[sidx] <= 1'b1;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (done == '0 && cyc < 200);
    check("done_seen", 64'(|done), 64'd1);
  endtask

  task automatic set_slot(input int i, input logic wr, input logic [31:0] a, input logic [31:0] d);
    req_write[i]        = wr;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  // Hold mask, drop each requester after its done; expect ids in order.
  task automatic grant_seq(input logic [3:0] mask, input logic [7:0] order, input int n);
    int cyc;
    logic [1:0] id;
    req = mask;
    for (int j = 0; j < n; j++) begin
      id = order[2*j +: 2];
      wait_done(cyc);
      check("rr_grant", 64'(done), 64'(4'b0001 << id));
      check("rr_latency", 64'(cyc), 64'd3);
      check("rr_rdata", 64'(rsp_rdata), 64'(32'hDEAD_0008 + 32'(id)));
      req = req & ~done;
    end
  endtask

  initial begin
    int cyc;
    int acc;
    int dn;
    presetn   = 1'b0;
    req       = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    pready    = 1'b1;
    pslverr   = 1'b0;
    tick();
    tick();
    check("rst_psel", 64'(psel), 64'd0);
    check("rst_penable", 64'(penable), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_paddr", 64'(paddr), 64'd0);
    check("rst_pwdata", 64'(pwdata), 64'd0);
    check("rst_rdata", 64'(rsp_rdata), 64'd0);
    check("rst_slverr", 64'(rsp_slverr), 64'd0);
    presetn = 1'b1;
    tick();

    // Single write, zero wait states
    set_slot(0, 1'b1, 32'h10, 32'hA5A5_0001);
    req = 4'b0001;
    tick();
    check("t1_psel_k1", 64'({psel, penable}), 64'b10);
    check("t1_paddr", 64'(paddr), 64'h10);
    check("t1_pwdata", 64'(pwdata), 64'hA5A5_0001);
    check("t1_pwrite", 64'(pwrite), 64'd1);
    tick();
    check("t1_penable_k2", 64'({psel, penable}), 64'b11);
    tick();
    check("t1_done_k3", 64'(done), 64'b0001);
    check("t1_slverr", 64'(rsp_slverr), 64'd0);
    check("t1_idle", 64'({psel, penable, busy}), 64'b000);
    check("t1_paddr_hold", 64'(paddr), 64'h10);
    req = '0;

    // Readback
    set_slot(0, 1'b0, 32'h10, 32'h0);
    req = 4'b0001;
    wait_done(cyc);
    check("t2_done", 64'(done), 64'b0001);
    check("t2_latency", 64'(cyc), 64'd3);
    check("t2_rdata", 64'(rsp_rdata), 64'hA5A5_0001);
    req = '0;

    // ptr is 1 here; a lone req[3] moves it back to 0
    set_slot(3, 1'b0, 32'h40, 32'h0);
    req = 4'b1000;
    wait_done(cyc);
    check("t3_pre_done", 64'(done), 64'b1000);
    check("t3_pre_rdata", 64'(rsp_rdata), 64'hDEAD_0000);
    req = '0;

    // Fairness
    for (int i = 0; i < NUM_REQ; i++) set_slot(i, 1'b0, 32'h20 + 32'(4*i), 32'h0);
    grant_seq(4'b1111, {2'd3, 2'd2, 2'd1, 2'd0}, 4);
    grant_seq(4'b1001, {2'd0, 2'd0, 2'd3, 2'd0}, 2);

    // Wait states: three pready-low ACCESS cycles
    set_slot(1, 1'b1, 32'h30, 32'h1234_5678);
    pready = 1'b0;
    req    = 4'b0010;
    tick();
    check("t4_setup", 64'({psel, penable}), 64'b10);
    acc = 0;
    for (int j = 0; j < 4; j++) begin
      tick();
      acc += int'(penable);
      check("t4_paddr_stable", 64'(paddr), 64'h30);
      check("t4_pwdata_stable", 64'(pwdata), 64'h1234_5678);
      check("t4_no_early_done", 64'(done), 64'd0);
      if (j == 3) pready = 1'b1;
    end
    tick();
    check("t4_penable_cycles", 64'(acc), 64'd4);
    check("t4_done_k6", 64'(done), 64'b0010);
    req = '0;

    // Slave error propagates on a normal completion
    set_slot(2, 1'b0, 32'h30, 32'h0);
    pslverr = 1'b1;
    req     = 4'b0100;
    wait_done(cyc);
    check("t4_err_done", 64'(done), 64'b0100);
    check("t4_err_slverr", 64'(rsp_slverr), 64'd1);
    check("t4_err_rdata", 64'(rsp_rdata), 64'h1234_5678);
    pslverr = 1'b0;
    req     = '0;

    // Watchdog expiry
    set_slot(3, 1'b0, 32'h40, 32'h0);
    pready = 1'b0;
    req    = 4'b1000;
    tick();
    acc = 0;
    dn  = 0;
    for (int j = 0; j < TIMEOUT; j++) begin
      tick();
      acc += int'(penable);
      dn  += int'(|done);
    end
    check("t5_access_cycles", 64'(acc), 64'd16);
    check("t5_no_early_done", 64'(dn), 64'd0);
    tick();
    check("t5_done", 64'(done), 64'b1000);
    check("t5_slverr", 64'(rsp_slverr), 64'd1);
    check("t5_rdata", 64'(rsp_rdata), 64'd0);
    check("t5_psel_low", 64'({psel, penable}), 64'b00);
    pready = 1'b1;
    set_slot(0, 1'b1, 32'h44, 32'h0BAD_CAFE);
    req = 4'b0001;
    wait_done(cyc);
    check("t5_next_done", 64'(done), 64'b0001);
    check("t5_next_latency", 64'(cyc), 64'd3);
    check("t5_next_slverr", 64'(rsp_slverr), 64'd0);
    req = '0;

    // Asynchronous reset during ACCESS
    set_slot(1, 1'b0, 32'h10, 32'h0);
    pready = 1'b0;
    req    = 4'b0010;
    tick();
    tick();
    check("t6_in_access", 64'({psel, penable}), 64'b11);
    #2 presetn = 1'b0;
    #1;
    check("t6_async_drop", 64'({psel, penable, busy}), 64'b000);
    tick();
    check("t6_no_done", 64'(done), 64'd0);
    presetn = 1'b1;
    pready  = 1'b1;
    set_slot(2, 1'b0, 32'h10, 32'h0);
    req = 4'b0100;
    wait_done(cyc);
    check("t6_grant2", 64'(done), 64'b0100);
    check("t6_latency", 64'(cyc), 64'd3);
    check("t6_rdata", 64'(rsp_rdata), 64'hA5A5_0001);
    req = '0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
